// File: rtl/fp_mul_pkg.sv
// Shared definitions for the sequential floating-point multiplier.
// Provides the FSM state enum, the operand special-case class, flag bit
// positions, default format widths and width-parametrised encoders for
// the special results (qNaN, Inf, zero, largest finite).
// The encoders return a 64-bit word; callers cast to their own width,
// so formats up to 64 bits wide are supported.
package fp_mul_pkg;

    localparam int DEF_EXP_W  = 8;
    localparam int DEF_FRAC_W = 23;
    localparam int FP_MAX_W   = 64;

    // Bit positions inside flags = {invalid, overflow, underflow, inexact}.
    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_NORM,
        ST_PACK,
        ST_DONE
    } state_e;

    // Special-case outcome decided when the operands are accepted.
    typedef enum logic [2:0] {
        SP_NONE,      // ordinary finite x finite product
        SP_QNAN,      // a NaN operand: canonical qNaN, no flag
        SP_QNAN_INV,  // Inf x 0: canonical qNaN, invalid
        SP_INF,       // Inf x finite: signed Inf
        SP_ZERO       // zero x finite: signed zero
    } special_e;

    function automatic logic [FP_MAX_W-1:0] fp_zero(input logic sign, input int exp_w,
                                                    input int frac_w);
        return FP_MAX_W'(sign) << (exp_w + frac_w);
    endfunction

    function automatic logic [FP_MAX_W-1:0] fp_inf(input logic sign, input int exp_w,
                                                   input int frac_w);
        logic [FP_MAX_W-1:0] one;
        one = FP_MAX_W'(1);
        return fp_zero(sign, exp_w, frac_w) | (((one << exp_w) - one) << frac_w);
    endfunction

    // Positive canonical quiet NaN: all-ones exponent, fraction MSB set.
    function automatic logic [FP_MAX_W-1:0] fp_qnan(input int exp_w, input int frac_w);
        logic [FP_MAX_W-1:0] one;
        one = FP_MAX_W'(1);
        return fp_inf(1'b0, exp_w, frac_w) | (one << (frac_w - 1));
    endfunction

    function automatic logic [FP_MAX_W-1:0] fp_max(input logic sign, input int exp_w,
                                                   input int frac_w);
        logic [FP_MAX_W-1:0] one;
        one = FP_MAX_W'(1);
        return fp_zero(sign, exp_w, frac_w) | (((one << exp_w) - (one << 1)) << frac_w)
               | ((one << frac_w) - one);
    endfunction

endpackage

// File: rtl/fp_mant_mul_seq.sv
// Iterative shift-add significand multiplier.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   start_i        load operands and begin; takes exactly M cycles
//   mcand_i        multiplicand significand (M bits)
//   mplier_i       multiplier significand (M bits)
//   done_o         high during the last iteration cycle
//   product_o      2M-bit product, final on the cycle after done_o
// The low half of the product register starts as the multiplier and is
// shifted out one bit per cycle while the partial sum fills the top.
module fp_mant_mul_seq #(
    parameter int M = 24
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic [M-1:0]   mcand_i,
    input  logic [M-1:0]   mplier_i,
    output logic           done_o,
    output logic [2*M-1:0] product_o
);

    localparam int CNT_W = $clog2(M + 1);

    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic [M-1:0]     mcand_q;
    logic [2*M-1:0]   prod_q;
    logic [2*M-1:0]   prod_d;
    logic [M:0]       sum;

    // Add the multiplicand when the current multiplier bit is set, then
    // shift the whole register right; the carry lands in the top bit.
    assign sum    = {1'b0, prod_q[2*M-1:M]} + (prod_q[0] ? {1'b0, mcand_q} : {(M+1){1'b0}});
    assign prod_d = {sum, prod_q[M-1:1]};

    assign done_o    = busy_q && (cnt_q == CNT_W'(M - 1));
    assign product_o = prod_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
        end else if (busy_q) begin
            cnt_q <= cnt_q + 1'b1;
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end

    // NOTE: pure datapath registers are always loaded by start_i before
    // they are read, so they carry no reset.
    always_ff @(posedge clk_i) begin
        if (start_i) begin
            mcand_q <= mcand_i;
            prod_q  <= {{M{1'b0}}, mplier_i};
        end else if (busy_q) begin
            prod_q <= prod_d;
        end
    end

endmodule

// File: rtl/fp_mul_seq.sv
// Handshaked sequential IEEE-754 multiplier (parametrised format).
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (ready only in IDLE)
//   a, b                  IEEE operands, W = 1+EXP_W+FRAC_W bits
//   out_valid / out_ready result handshake; result held until accepted
//   result                IEEE product
//   flags                 {invalid, overflow, underflow, inexact}
// Build option: define FP_MUL_ROUND_EN for round-to-nearest-even with
// overflow to Inf; otherwise results truncate and overflow saturates to
// the largest finite value. Denormal operands are flushed to zero.
// Latency from acceptance to out_valid is M+2 cycles for every operand.
module fp_mul_seq
    import fp_mul_pkg::*;
#(
    parameter int EXP_W  = DEF_EXP_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [EXP_W+FRAC_W:0]   a,
    input  logic [EXP_W+FRAC_W:0]   b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   result,
    output logic [3:0]              flags
);

    localparam int M  = FRAC_W + 1;
    localparam int W  = 1 + EXP_W + FRAC_W;
    localparam int XW = EXP_W + 2;   // signed working exponent width
    localparam logic [XW-1:0] BIAS_X  = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

    state_e            state_q, state_d;
    logic              mul_start, mul_done;
    logic [2*M-1:0]    prod;

    logic              sign_q;
    logic [EXP_W-1:0]  exp_a_q, exp_b_q;
    special_e          spec_q, spec_d;
    logic [FRAC_W-1:0] mant_q, mant_d;
    logic              guard_q, guard_d, sticky_q, sticky_d;
    logic [XW-1:0]     exp_q, exp_d;
    logic [W-1:0]      result_q, result_d;
    logic [3:0]        flags_q, flags_d;

    logic [EXP_W-1:0]  a_exp, b_exp;
    logic              a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic [2*M-1:0]    prod_sh;
    logic              round_up;
    logic [FRAC_W:0]   mant_rnd;
    logic [XW-1:0]     exp_rnd;

    fp_mant_mul_seq #(.M(M)) u_mant (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (mul_start),
        .mcand_i   ({1'b1, a[FRAC_W-1:0]}),
        .mplier_i  ({1'b1, b[FRAC_W-1:0]}),
        .done_o    (mul_done),
        .product_o (prod)
    );

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mul_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mul_start = 1'b1;
                    state_d   = ST_MUL;
                end
            end
            ST_MUL:  if (mul_done) state_d = ST_NORM;
            ST_NORM: state_d = ST_PACK;
            ST_PACK: state_d = ST_DONE;
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- operand classification ----------------
    assign a_exp = a[W-2:FRAC_W];
    assign b_exp = b[W-2:FRAC_W];

    always_comb begin
        a_zero = (a_exp == '0);
        b_zero = (b_exp == '0);
        a_inf  = (a_exp == '1) && (a[FRAC_W-1:0] == '0);
        b_inf  = (b_exp == '1) && (b[FRAC_W-1:0] == '0);
        a_nan  = (a_exp == '1) && (a[FRAC_W-1:0] != '0);
        b_nan  = (b_exp == '1) && (b[FRAC_W-1:0] != '0);
        if (a_nan || b_nan)                            spec_d = SP_QNAN;
        else if ((a_inf && b_zero) || (a_zero && b_inf)) spec_d = SP_QNAN_INV;
        else if (a_inf || b_inf)                       spec_d = SP_INF;
        else if (a_zero || b_zero)                     spec_d = SP_ZERO;
        else                                           spec_d = SP_NONE;
    end

    // ---------------- normalise ----------------
    // A product below 2.0 is shifted left once so both cases share one slice.
    always_comb begin
        prod_sh  = prod[2*M-1] ? prod : (prod << 1);
        mant_d   = prod_sh[2*M-2:M];
        guard_d  = prod_sh[M-1];
        sticky_d = |prod_sh[M-2:0];
        exp_d    = {2'b00, exp_a_q} + {2'b00, exp_b_q} - BIAS_X + XW'(prod[2*M-1]);
    end

    // ---------------- round and pack ----------------
    always_comb begin
`ifdef FP_MUL_ROUND_EN
        round_up = guard_q && (sticky_q || mant_q[0]);
`else
        round_up = 1'b0;
`endif
        mant_rnd = {1'b0, mant_q} + (FRAC_W+1)'(round_up);
        // A carry out of the fraction means 1.11..1 rounded to 10.0: bump
        // the exponent; the fraction bits are already all zero.
        exp_rnd  = exp_q + XW'(mant_rnd[FRAC_W]);

        result_d = {sign_q, exp_rnd[EXP_W-1:0], mant_rnd[FRAC_W-1:0]};
        flags_d  = '0;
        flags_d[FLAG_INEXACT] = guard_q | sticky_q;

        if ($signed(exp_rnd) >= $signed(EXP_MAX)) begin
            flags_d[FLAG_OVERFLOW] = 1'b1;
            flags_d[FLAG_INEXACT]  = 1'b1;
`ifdef FP_MUL_ROUND_EN
            result_d = W'(fp_inf(sign_q, EXP_W, FRAC_W));
`else
            result_d = W'(fp_max(sign_q, EXP_W, FRAC_W));
`endif
        end else if (exp_rnd[XW-1] || (exp_rnd == '0)) begin
            flags_d[FLAG_UNDERFLOW] = 1'b1;
            flags_d[FLAG_INEXACT]   = 1'b1;
            result_d = W'(fp_zero(sign_q, EXP_W, FRAC_W));
        end

        // Specials ignore whatever the significand datapath produced.
        case (spec_q)
            SP_QNAN: begin
                result_d = W'(fp_qnan(EXP_W, FRAC_W));
                flags_d  = '0;
            end
            SP_QNAN_INV: begin
                result_d = W'(fp_qnan(EXP_W, FRAC_W));
                flags_d  = '0;
                flags_d[FLAG_INVALID] = 1'b1;
            end
            SP_INF: begin
                result_d = W'(fp_inf(sign_q, EXP_W, FRAC_W));
                flags_d  = '0;
            end
            SP_ZERO: begin
                result_d = W'(fp_zero(sign_q, EXP_W, FRAC_W));
                flags_d  = '0;
            end
            default: ;
        endcase
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            flags_q  <= '0;
        end else if (state_q == ST_PACK) begin
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mul_start) begin
            sign_q  <= a[W-1] ^ b[W-1];
            exp_a_q <= a_exp;
            exp_b_q <= b_exp;
            spec_q  <= spec_d;
        end
        if (state_q == ST_NORM) begin
            mant_q   <= mant_d;
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
            exp_q    <= exp_d;
        end
    end

    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed testbench for fp_mul_seq (single precision defaults).
// Expected values are hand-computed; the rounding-dependent vectors select
// their expectation from FP_MUL_ROUND_EN.
module tb_fp_mul_seq;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int M      = FRAC_W + 1;
    localparam int W      = 1 + EXP_W + FRAC_W;

    localparam logic [3:0] F_NONE  = 4'b0000;
    localparam logic [3:0] F_INV   = 4'b1000;
    localparam logic [3:0] F_OVF   = 4'b0101;   // overflow + inexact
    localparam logic [3:0] F_UNF   = 4'b0011;   // underflow + inexact
    localparam logic [3:0] F_INX   = 4'b0001;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;

    int n_vec = 0;
    int n_err = 0;

    fp_mul_seq #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Present operands once in_ready is seen; returns just after the
    // acceptance edge with in_valid dropped.
    task automatic send(input string tag, input logic [W-1:0] op_a, input logic [W-1:0] op_b);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 64'(in_ready), 64'(1));
        a        = op_a;
        b        = op_b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_in_ready_after"}, 64'(in_ready), 64'(1));
        check({tag, "_valid_after"}, 64'(out_valid), 64'(0));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                          input logic [W-1:0] exp_res, input logic [3:0] exp_flags);
        int lat;
        send(tag, op_a, op_b);
        wait_out(lat);
        check({tag, "_latency"}, 64'(lat), 64'(M + 2));
        check({tag, "_result"}, 64'(result), 64'(exp_res));
        check({tag, "_flags"}, 64'(flags), 64'(exp_flags));
        handshake(tag);
    endtask

    initial begin
        int lat;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_result", 64'(result), 64'(0));
        check("rst_flags", 64'(flags), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // Ordinary products: no shift, then the normalise-shift path.
        run_op("mul_3x2p5", 32'h4040_0000, 32'h4020_0000, 32'h40F0_0000, F_NONE);
        run_op("mul_1p5sq", 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, F_NONE);
`ifdef FP_MUL_ROUND_EN
        run_op("round", 32'h3FC0_0001, 32'h3FC0_0001, 32'h4010_0002, F_INX);
        run_op("ovf", 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, F_OVF);
`else
        run_op("round", 32'h3FC0_0001, 32'h3FC0_0001, 32'h4010_0001, F_INX);
        run_op("ovf", 32'h7F00_0000, 32'h7F00_0000, 32'h7F7F_FFFF, F_OVF);
`endif
        run_op("inf_x_0", 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, F_INV);
        run_op("ninf_x_2", 32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, F_NONE);
        run_op("unf", 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, F_UNF);
        run_op("nan_x_1", 32'hFFA0_0000, 32'h3F80_0000, 32'h7FC0_0000, F_NONE);
        run_op("nzero_x_2", 32'h8000_0000, 32'h4000_0000, 32'h8000_0000, F_NONE);

        // Backpressure: result held for 10 cycles, a second in_valid ignored.
        send("bp", 32'h4040_0000, 32'h4020_0000);
        wait_out(lat);
        check("bp_latency", 64'(lat), 64'(M + 2));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a        = 32'h3F80_0000;
            b        = 32'h3F80_0000;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check("bp_result_hold", 64'(result), 64'h40F0_0000);
            check("bp_valid_hold", 64'(out_valid), 64'(1));
            check("bp_in_ready_low", 64'(in_ready), 64'(0));
        end
        @(negedge clk);
        in_valid = 1'b0;
        handshake("bp");
        repeat (3) @(posedge clk);
        #1;
        check("bp_ignored_no_op", 64'(out_valid), 64'(0));
        check("bp_ignored_idle", 64'(in_ready), 64'(1));

        // Reset in the middle of MUL aborts the operation.
        send("rst_mid", 32'h4040_0000, 32'h4020_0000);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_in_ready", 64'(in_ready), 64'(1));
        check("rst_mid_out_valid", 64'(out_valid), 64'(0));
        check("rst_mid_result", 64'(result), 64'(0));
        check("rst_mid_flags", 64'(flags), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (M + 6) @(posedge clk);
        #1;
        check("rst_mid_no_output", 64'(out_valid), 64'(0));
        run_op("after_rst", 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, F_NONE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
